// File: rtl/multdiv_if.sv
// multdiv_if: start/operand/result bundle between the execute stage and the
// iterative multiply/divide unit.
//   ctrl_MULT, ctrl_DIV            one-cycle start pulses (multiply wins if both)
//   data_operandA, data_operandB   32-bit two's complement operands
//   data_result                    product low word or quotient
//   data_exception                 overflow / divide-by-zero flag
//   data_resultRDY                 one-cycle pulse, result and exception valid
// master: the requester (pipeline / testbench); slave: the multdiv unit.
interface multdiv_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv.sv
// multdiv: iterative signed 32-bit multiply/divide unit, one shift step per cycle.
//   clock   rising-edge clock
//   reset   asynchronous, active-high
//   bus     multdiv_if.slave: start pulses, operands, result/exception/ready
// Optional feature macro MULTDIV_BOOTH_EN: radix-4 Booth multiply, 16 steps on
// signed operands. Undefined: radix-2 shift-add on magnitudes, MULT_CYCLES steps.
// Divide is restoring division on magnitudes in either build.
module multdiv #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);
`ifdef MULTDIV_BOOTH_EN
    localparam int MULT_STEPS = 16;
    // Two guard bits absorb +/-2A partial products on signed operands.
    localparam int HI_W = 34;
`else
    localparam int MULT_STEPS = MULT_CYCLES;
    localparam int HI_W = 32;
`endif
    localparam logic [5:0] MULT_LAST = 6'(MULT_STEPS);
    localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t                  state, state_nx;
    logic [5:0]              cnt;
    logic signed [HI_W-1:0]  hi;
    logic [31:0]             lo;
    logic [31:0]             opnd;
    logic                    neg;
    logic [31:0]             result_q;
    logic                    exc_q;
`ifdef MULTDIV_BOOTH_EN
    logic                    lo_x;
`endif

    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        // |0x80000000| is 0x80000000, which is still correct as unsigned.
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [63:0] apply_sign(input logic [63:0] m, input logic n);
        return n ? -m : m;
    endfunction

    function automatic logic mul_ovf(input logic [63:0] p);
        return !((&p[63:31]) || !(|p[63:31]));
    endfunction

    logic start, mult_last, div_last;
    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign mult_last = (cnt == MULT_LAST);
    assign div_last  = (cnt == DIV_LAST);

    // Multiply step and final product
    logic [63:0] prod;
`ifdef MULTDIV_BOOTH_EN
    logic signed [HI_W-1:0] a_ext, pp, bsum;
    assign a_ext = signed'({{2{opnd[31]}}, opnd});
    always_comb begin
        pp = '0;
        case ({lo[1:0], lo_x})
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext <<< 1;
            3'b100:         pp = -(a_ext <<< 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
    end
    assign bsum = hi + pp;
    assign prod = {hi[31:0], lo};
`else
    logic [32:0] add_sum;
    assign add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
    assign prod    = apply_sign({hi, lo}, neg);
`endif

    // Divide step: remainder in hi, dividend shifting out of lo, quotient in.
    logic [32:0] div_shift, div_diff;
    logic [31:0] quot;
    logic        div_zero;
    assign div_shift = {hi[31:0], lo[31]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign quot      = neg ? -lo : lo;
    assign div_zero  = (opnd == 32'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.ctrl_MULT)     state_nx = MULT;
        else if (bus.ctrl_DIV) state_nx = DIV;
        else begin
            case (state)
                MULT:    if (mult_last) state_nx = DONE;
                DIV:     if (div_last)  state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            neg      <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
            lo_x     <= 1'b0;
`endif
        end else if (start) begin
            cnt <= '0;
            hi  <= '0;
            neg <= bus.data_operandA[31] ^ bus.data_operandB[31];
            if (bus.ctrl_MULT) begin
`ifdef MULTDIV_BOOTH_EN
                opnd <= bus.data_operandA;
                lo   <= bus.data_operandB;
                lo_x <= 1'b0;
`else
                opnd <= mag32(bus.data_operandA);
                lo   <= mag32(bus.data_operandB);
`endif
            end else begin
                opnd <= mag32(bus.data_operandB);
                lo   <= mag32(bus.data_operandA);
            end
        end else begin
            case (state)
                MULT: begin
                    if (mult_last) begin
                        result_q <= prod[31:0];
                        exc_q    <= mul_ovf(prod);
                    end else begin
                        cnt <= cnt + 6'd1;
`ifdef MULTDIV_BOOTH_EN
                        hi   <= {{2{bsum[HI_W-1]}}, bsum[HI_W-1:2]};
                        lo   <= {bsum[1:0], lo[31:2]};
                        lo_x <= lo[1];
`else
                        hi <= add_sum[32:1];
                        lo <= {add_sum[0], lo[31:1]};
`endif
                    end
                end
                DIV: begin
                    if (div_last) begin
                        // Magnitude quotient >= 2^31 with a positive sign is
                        // only reachable as 0x80000000 / -1.
                        result_q <= div_zero ? 32'd0 : quot;
                        exc_q    <= div_zero | (~neg & lo[31]);
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (!div_diff[32]) begin
                            hi <= HI_W'(div_diff[31:0]);
                            lo <= {lo[30:0], 1'b1};
                        end else begin
                            hi <= HI_W'(div_shift[31:0]);
                            lo <= {lo[30:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state == DONE);
endmodule
